// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw switch input in, clean level and press tick out.
`timescale 1ns/1ps
interface button_debouncer_if;
   logic sw;
   logic db_level;
   logic db_tick;

   // Source of the raw switch and consumer of the debounced outputs
   modport master (
      output sw,
      input  db_level,
      input  db_tick
   );

   // The debouncer itself
   modport slave (
      input  sw,
      output db_level,
      output db_tick
   );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer: 2-FF synchronizer, stability counter and 4-state FSM
// producing a clean level and a one-cycle pulse on each accepted press.
`timescale 1ns/1ps
module button_debouncer #(
   parameter int unsigned DB_CYCLES = 1_000_000,
   parameter int unsigned CNT_W     = 20,
   parameter bit          IN_INV    = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   button_debouncer_if.slave  db_if
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_tick;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tick_nxt;
   logic             w_level_nxt;

   // Two-flop synchronizer on the (optionally inverted) raw input
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= db_if.sw ^ IN_INV;
         r_s2 <= r_s1;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ZERO;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   // Next-state, counter and output decode; counter only loads on WAIT entry and stops at 0
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tick_nxt  = 1'b0;
      case (r_state)
         ZERO: begin
            if (r_s2) begin
               w_state_nxt = WAIT1;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         WAIT1: begin
            if (!r_s2) begin
               w_state_nxt = ZERO;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = ONE;
               w_tick_nxt  = 1'b1;
            end
         end
         ONE: begin
            if (!r_s2) begin
               w_state_nxt = WAIT0;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         WAIT0: begin
            if (r_s2) begin
               w_state_nxt = ONE;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = ZERO;
            end
         end
         default: begin
            w_state_nxt = ZERO;
            w_cnt_nxt   = '0;
         end
      endcase
      w_level_nxt = (w_state_nxt == ONE) || (w_state_nxt == WAIT0);
   end

   assign db_if.db_level = r_level;
   assign db_if.db_tick  = r_tick;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus pushes hand-computed expected
// outputs per cycle, a monitor pops and compares just after each rising edge.
`timescale 1ns/1ps
module tb_button_debouncer;

   typedef struct packed {
      logic l0;
      logic t0;
      logic l1;
      logic t1;
   } exp_t;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   button_debouncer_if dif0 ();
   button_debouncer_if dif1 ();

   button_debouncer #(.DB_CYCLES(4), .CNT_W(3), .IN_INV(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .db_if (dif0.slave)
   );

   button_debouncer #(.DB_CYCLES(4), .CNT_W(3), .IN_INV(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .db_if (dif1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
      end
   endtask

   // Drive one cycle of inputs before the next rising edge and queue what must follow it
   task automatic step(input logic rst, input logic s0, input logic s1,
                       input logic l0, input logic t0, input logic l1, input logic t1);
      exp_t e;
      @(negedge clk);
      reset    = rst;
      dif0.sw  = s0;
      dif1.sw  = s1;
      e.l0 = l0; e.t0 = t0; e.l1 = l1; e.t1 = t1;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("dut0_level", dif0.db_level, e.l0);
            cmp("dut0_tick",  dif0.db_tick,  e.t0);
            cmp("dut1_level", dif1.db_level, e.l1);
            cmp("dut1_tick",  dif1.db_tick,  e.t1);
         end
      end
   end

   initial begin
      reset   = 1'b0;
      dif0.sw = 1'b0;
      dif1.sw = 1'b1;

      // 1: reset held while sw toggles, then release with sw low
      for (int i = 0; i < 8; i++) step(1'b0, 1'(i % 2), 1'(i % 2), 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);

      // 2: clean press, level and tick after six edges
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, (i >= 6), (i == 6), 0, 0);

      // 4: release bounce (three low cycles) is rejected
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1, 0, 0, 0);
      // 4: held release, level falls after six edges, no tick
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, (i < 6), 0, 0, 0);

      // 3: press bounce 1,0,1,1,0 then low
      step(1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
      step(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
      // 3: hold high ten cycles, exactly one tick
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, (i >= 6), (i == 6), 0, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, (i < 6), 0, 0, 0);

      // 5: reset in WAIT1 with cnt=2 discards progress
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, (i >= 6), (i == 6), 0, 0);

      // Reset while pressed clears the level at once
      step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);

      // 6: active-low instance, press by driving sw low then release
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0, 0, (i >= 6), (i == 6));
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 0, 0, (i < 6), 0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
